bin2bcd_seq: RTL and testbench

//   Sequential, parametrised binary-to-packed-BCD converter (iterative double-dabble, one bit/cycle).

---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bcd_dabble_digit.sv | 11 +
 rtl/bin2bcd_seq.sv | 82 ++++++++
 tb/tb_bin2bcd_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bin2bcd_state_e;

  // Minimum BCD digits needed to hold 2^bin_w - 1.
  // floor(bin_w*log10(2)) + 1; 2^n is never a power of ten, so this matches 2^n - 1.
  function automatic int bcd_digits(int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble correction digit: add 3 when the digit is 5 or more.
module bcd_dabble_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter, one input bit per cycle, valid/ready on both sides.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BinW   = 16,
  parameter int unsigned Digits = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BinW-1:0]       in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*Digits-1:0]   out_bcd_o,
  output logic                  out_ovf_o,
  output logic                  busy_o
);

  localparam int unsigned BcdW = 4 * Digits;
  localparam int unsigned CntW = $clog2(BinW);

  bin2bcd_state_e  state_q;
  logic [BinW-1:0] bin_q;
  logic [BcdW-1:0] bcd_q;
  logic            ovf_q;
  logic [CntW-1:0] cnt_q;

  logic [BcdW-1:0] bcd_adj;

  for (genvar g = 0; g < Digits; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            bin_q   <= in_data_i;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CntW'(BinW - 1);
            state_q <= StShift;
          end
        end
        StShift: begin
          // {bcd,bin} shift as one vector; the bit leaving the top digit is lost magnitude.
          bcd_q   <= {bcd_adj[BcdW-2:0], bin_q[BinW-1]};
          bin_q   <= {bin_q[BinW-2:0], 1'b0};
          ovf_q   <= ovf_q | bcd_adj[BcdW-1];
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign out_bcd_o   = bcd_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit instance share stimulus; results vs decimal model.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int unsigned BinW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;

  logic        in_ready_a, out_valid_a, ovf_a, busy_a;
  logic [19:0] bcd_a;
  logic        in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [15:0] bcd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BinW(BinW), .Digits(5)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_a),
    .in_data_i   (in_data),
    .out_valid_o (out_valid_a),
    .out_ready_i (out_ready),
    .out_bcd_o   (bcd_a),
    .out_ovf_o   (ovf_a),
    .busy_o      (busy_a)
  );

  bin2bcd_seq #(.BinW(BinW), .Digits(4)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_b),
    .in_data_i   (in_data),
    .out_valid_o (out_valid_b),
    .out_ready_i (out_ready),
    .out_bcd_o   (bcd_b),
    .out_ovf_o   (ovf_b),
    .busy_o      (busy_b)
  );

  typedef struct {
    logic [15:0] val;
    logic [19:0] exp_a;
    logic [15:0] exp_b;
    logic        ovf_b;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Decimal reference: digits by repeated division, overflow if anything is left over.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits,
                                          output logic ovf);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    ovf = (x != 0);
    return r;
  endfunction

  // Entered and left at a negedge. Checks result exactly BinW cycles after the accept edge.
  task automatic send(input logic [15:0] v, input logic [19:0] exp_a, input logic [15:0] exp_b,
                      input logic exp_ovf_b, input string name, input bit drain);
    int  w;
    logic early;
    w = 0;
    while (!in_ready_a && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({name, "_rdy"}, 32'(in_ready_a), 32'd1);
    if (!in_ready_a) return;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check({name, "_busy"}, 32'(busy_a), 32'd1);
    early = 1'b0;
    for (int k = 1; k < BinW; k++) begin
      @(negedge clk);
      early = early | out_valid_a | out_valid_b;
    end
    check({name, "_early"}, 32'(early), 32'd0);
    @(negedge clk);
    check({name, "_valid_a"}, 32'(out_valid_a), 32'd1);
    check({name, "_bcd_a"}, 32'(bcd_a), 32'(exp_a));
    check({name, "_ovf_a"}, 32'(ovf_a), 32'd0);
    check({name, "_valid_b"}, 32'(out_valid_b), 32'd1);
    check({name, "_bcd_b"}, 32'(bcd_b), 32'(exp_b));
    check({name, "_ovf_b"}, 32'(ovf_b), 32'(exp_ovf_b));
    if (drain) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_drop"}, 32'(out_valid_a), 32'd0);
      check({name, "_idle"}, 32'(in_ready_a), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[11];
    logic [15:0] words[3];
    logic [19:0] expw[3];
    logic [31:0] ea, eb;
    logic        oa, ob;
    logic [15:0] rv;
    logic        early;
    int          idx, got, last_out;
    bit          acc;

    vecs[0]  = '{16'd0,     20'h00000, 16'h0000, 1'b0};
    vecs[1]  = '{16'd1,     20'h00001, 16'h0001, 1'b0};
    vecs[2]  = '{16'd9,     20'h00009, 16'h0009, 1'b0};
    vecs[3]  = '{16'd10,    20'h00010, 16'h0010, 1'b0};
    vecs[4]  = '{16'd19,    20'h00019, 16'h0019, 1'b0};
    vecs[5]  = '{16'd20,    20'h00020, 16'h0020, 1'b0};
    vecs[6]  = '{16'd7321,  20'h07321, 16'h7321, 1'b0};
    vecs[7]  = '{16'd65535, 20'h65535, 16'h5535, 1'b1};
    vecs[8]  = '{16'd255,   20'h00255, 16'h0255, 1'b0};
    vecs[9]  = '{16'd12345, 20'h12345, 16'h2345, 1'b1};
    vecs[10] = '{16'd9999,  20'h09999, 16'h9999, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("pkg_digits16", 32'(bcd_digits(16)), 32'd5);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].val, vecs[i].exp_a, vecs[i].exp_b, vecs[i].ovf_b,
           $sformatf("vec%0d", i), 1'b1);
    end

    // Backpressure: result held, input ignored, no new accept until drained.
    send(16'd1234, 20'h01234, 16'h1234, 1'b0, "bp", 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd999;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_bcd", 32'(bcd_a), 32'h01234);
      check("bp_hold_valid", 32'(out_valid_a), 32'd1);
      check("bp_in_ready", 32'(in_ready_a), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready_a), 32'd1);
    check("bp_release_valid", 32'(out_valid_a), 32'd0);
    send(16'd555, 20'h00555, 16'h0555, 1'b0, "bp_next", 1'b1);

    // Back-to-back with in_valid and out_ready both held high.
    words[0] = 16'd11;   words[1] = 16'd12;   words[2] = 16'd16;
    expw[0]  = 20'h00011; expw[1] = 20'h00012; expw[2] = 20'h00016;
    idx = 0; got = 0; last_out = -1;
    in_data   = words[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc = in_ready_a && in_valid;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      @(negedge clk);
      if (out_valid_a) begin
        check($sformatf("b2b_bcd%0d", got), 32'(bcd_a), 32'(expw[got]));
        if (got > 0) check("b2b_spacing", 32'(cyc - last_out), 32'(BinW + 2));
        last_out = cyc;
        got++;
      end
      if (acc) begin
        idx++;
        if (idx < 3) in_data = words[idx];
        else in_valid = 1'b0;
      end
      acc = in_ready_a && in_valid;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_count", 32'(got), 32'd3);

    // Async reset in the middle of a conversion.
    in_valid = 1'b1;
    in_data  = 16'd4321;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
    check("mid_rst_valid", 32'(out_valid_a), 32'd0);
    check("mid_rst_bcd", 32'(bcd_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      early = early | out_valid_a | out_valid_b;
    end
    check("mid_rst_no_valid", 32'(early), 32'd0);
    send(16'd42, 20'h00042, 16'h0042, 1'b0, "post_rst", 1'b1);

    for (int i = 0; i < 24; i++) begin
      rv = 16'($urandom_range(0, 65535));
      ea = ref_bcd(32'(rv), 5, oa);
      eb = ref_bcd(32'(rv), 4, ob);
      send(rv, ea[19:0], eb[15:0], ob, $sformatf("rand%0d_%0d", i, rv), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
